uart_tx_arbiter: RTL and testbench

Round-robin, message-locked arbiter that shares one UART transmit FIFO between NUM_REQ byte-stream requesters (e.g. CPU register port, DMA engine, loopback/test source). It sits directly upstream of the TX FIFO write port. Each message is a sequence of bytes terminated by a `last` flag, and it lands in the FIFO contiguously, never interleaved with another requester's bytes. The arbiter also refuses to start a new message while the FIFO reports almost-full.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_arbiter_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART-side definitions: arbiter FSM encoding and index-width helper.
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  // Width of an index into n requesters; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first request strictly after last_i, with wrap.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IW-1:0]      idx_o
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((32'(last_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        pick_o[cand] = 1'b1;
        idx_o        = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter sharing one UART TX FIFO write port
// between NUM_REQ byte-stream requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_REQ-1:0]            i_last,
  output logic [NUM_REQ-1:0]            o_ready,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
  input  logic                          i_fifo_full,
  input  logic                          i_fifo_almost_full,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  state_e               state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 xfer_c;
  logic                 owner_valid_c;
  logic                 owner_last_c;
  logic                 wr_en_c;
  logic [DATA_WIDTH-1:0] wr_data_c;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .req_i  (i_valid),
    .last_i (last_owner_q),
    .pick_o (pick_oh),
    .idx_o  (pick_idx)
  );

  // State and ownership registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= IW'(NUM_REQ - 1);
      grant_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
    end
  end

  // grant_q is one-hot of the owner while locked, so it doubles as the owner select.
  assign xfer_c        = (state_q == ST_XFER);
  assign owner_valid_c = |(i_valid & grant_q);
  assign owner_last_c  = |(i_last & grant_q);
  assign wr_en_c       = xfer_c & owner_valid_c & ~i_fifo_full;

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|i_valid && !i_fifo_almost_full) begin
          state_d = ST_XFER;
          owner_d = pick_idx;
          grant_d = pick_oh;
          busy_d  = 1'b1;
        end
      end
      ST_XFER: begin
        if (wr_en_c && owner_last_c) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
          grant_d      = '0;
          busy_d       = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Owner byte mux; zero while idle.
  always_comb begin
    wr_data_c = '0;
    if (xfer_c) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (owner_q == IW'(k)) wr_data_c = i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign o_ready        = (xfer_c && !i_fifo_full) ? grant_q : '0;
  assign o_fifo_wr_en   = wr_en_c;
  assign o_fifo_wr_data = wr_data_c;
  assign o_grant        = grant_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed messages, expected FIFO writes
// queued up front and checked by an independent write monitor.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  valid;
  logic [15:0] data;
  logic [1:0]  last;
  logic        full, afull;
  logic [1:0]  ready, grant;
  logic        wr_en, busy;
  logic [7:0]  wr_data;

  logic [3:0]  v4, l4, ready4, grant4;
  logic [31:0] d4;
  logic        wr_en4, busy4;
  logic [7:0]  wr_data4;
  logic        zero4 = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(valid), .i_data(data), .i_last(last),
    .o_ready(ready), .o_fifo_wr_en(wr_en), .o_fifo_wr_data(wr_data),
    .i_fifo_full(full), .i_fifo_almost_full(afull), .o_grant(grant), .o_busy(busy)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_valid(v4), .i_data(d4), .i_last(l4),
    .o_ready(ready4), .o_fifo_wr_en(wr_en4), .o_fifo_wr_data(wr_data4),
    .i_fifo_full(zero4), .i_fifo_almost_full(zero4), .o_grant(grant4), .o_busy(busy4)
  );

  typedef struct {
    logic [1:0] grant;
    logic [7:0] data;
    int         gap;   // idle cycles since previous write, -1 = don't care
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] src0_q[$];
  logic [8:0] src1_q[$];
  logic [1:0] hs;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_wr = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic [7:0] d, input int gap);
    exp_t e;
    e.grant = g;
    e.data  = d;
    e.gap   = gap;
    exp_q.push_back(e);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_grant"},   32'(grant),   32'h0);
    chk({name, "_busy"},    32'(busy),    32'h0);
    chk({name, "_ready"},   32'(ready),   32'h0);
    chk({name, "_wr_en"},   32'(wr_en),   32'h0);
    chk({name, "_wr_data"}, 32'(wr_data), 32'h0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || src0_q.size() != 0 || src1_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL %s_timeout pending_writes=%0d expected=0", name, exp_q.size());
      exp_q.delete();
      src0_q.delete();
      src1_q.delete();
    end
  endtask

  // Requester model: holds the head byte until it is accepted.
  initial begin
    valid = '0;
    data  = '0;
    last  = '0;
    forever begin
      @(negedge clk);
      hs = valid & ready;
      @(posedge clk);
      #1;
      if (hs[0] && src0_q.size() != 0) void'(src0_q.pop_front());
      if (hs[1] && src1_q.size() != 0) void'(src1_q.pop_front());
      valid[0]   = (src0_q.size() != 0);
      valid[1]   = (src1_q.size() != 0);
      data[7:0]  = valid[0] ? src0_q[0][7:0] : 8'h00;
      data[15:8] = valid[1] ? src1_q[0][7:0] : 8'h00;
      last[0]    = valid[0] && src0_q[0][8];
      last[1]    = valid[1] && src1_q[0][8];
    end
  end

  // FIFO write monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (wr_en) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write data=%h grant=%b expected no write", wr_data, grant);
        end else begin
          e = exp_q.pop_front();
          if (wr_data !== e.data || grant !== e.grant || ready !== e.grant || full !== 1'b0 ||
              (e.gap >= 0 && (cyc - last_wr - 1) != e.gap)) begin
            bad++;
            $display("FAIL fifo_write got data=%h grant=%b ready=%b full=%b gap=%0d expected data=%h grant=%b gap=%0d",
                     wr_data, grant, ready, full, cyc - last_wr - 1, e.data, e.grant, e.gap);
          end
        end
        last_wr = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_g4[3];
    logic [7:0] exp_d4[3];
    int         idx;
    full  = 1'b0;
    afull = 1'b0;
    v4    = '0;
    l4    = '0;
    d4    = '0;

    // Reset values, then a 3-byte message from requester 0.
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    src0_q.push_back(9'h041); src0_q.push_back(9'h042); src0_q.push_back(9'h143);
    push(2'b01, 8'h41, -1); push(2'b01, 8'h42, 0); push(2'b01, 8'h43, 0);
    @(negedge clk); chk("s1_grant_idle", 32'(grant), 32'h0);
    @(negedge clk); chk("s1_grant", 32'(grant), 32'h1); chk("s1_wr_en", 32'(wr_en), 32'h1);
    @(negedge clk);
    @(negedge clk); chk("s1_busy_third", 32'(busy), 32'h1);
    @(negedge clk); chk("s1_busy_after", 32'(busy), 32'h0); chk("s1_grant_after", 32'(grant), 32'h0);
    drain("s1");

    // Fresh arbitration, both requesters streaming 2-byte messages.
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      src0_q.push_back(9'h0A0); src0_q.push_back(9'h1A1);
      src1_q.push_back(9'h0B0); src1_q.push_back(9'h1B1);
    end
    push(2'b01, 8'hA0, -1); push(2'b01, 8'hA1, 0);
    push(2'b10, 8'hB0, 1);  push(2'b10, 8'hB1, 0);
    push(2'b01, 8'hA0, 1);  push(2'b01, 8'hA1, 0);
    push(2'b10, 8'hB0, 1);  push(2'b10, 8'hB1, 0);
    drain("s2");

    // Almost-full blocks message start only.
    @(negedge clk);
    afull = 1'b1;
    src1_q.push_back(9'h1C5);
    push(2'b10, 8'hC5, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s3_no_grant", 32'(grant), 32'h0);
      chk("s3_no_busy",  32'(busy),  32'h0);
    end
    afull = 1'b0;
    @(negedge clk); chk("s3_grant", 32'(grant), 32'h2);
    drain("s3");

    // FIFO full stalls a locked 4-byte message on its second byte.
    @(negedge clk);
    src0_q.push_back(9'h0D0); src0_q.push_back(9'h0D1);
    src0_q.push_back(9'h0D2); src0_q.push_back(9'h1D3);
    push(2'b01, 8'hD0, -1); push(2'b01, 8'hD1, 3);
    push(2'b01, 8'hD2, 0);  push(2'b01, 8'hD3, 0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s4_ready_full", 32'(ready), 32'h0);
      chk("s4_wr_en_full", 32'(wr_en), 32'h0);
      chk("s4_grant_held", 32'(grant), 32'h1);
    end
    @(posedge clk); #1 full = 1'b0;
    drain("s4");

    // Reset mid-message: outputs drop at once, requester 0 wins afterwards.
    @(negedge clk);
    src0_q.push_back(9'h0E0); src0_q.push_back(9'h0E1); src0_q.push_back(9'h1E2);
    push(2'b01, 8'hE0, -1);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    src1_q.push_back(9'h0F0); src1_q.push_back(9'h1F1);
    #1;
    chk_idle_outputs("s5_async_reset");
    push(2'b01, 8'hE1, -1); push(2'b01, 8'hE2, 0);
    push(2'b10, 8'hF0, 1);  push(2'b10, 8'hF1, 0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    drain("s5");

    // Four requesters, 4'b1010 requesting single-byte messages.
    exp_g4[0] = 4'b0010; exp_d4[0] = 8'h11;
    exp_g4[1] = 4'b1000; exp_d4[1] = 8'h33;
    exp_g4[2] = 4'b0010; exp_d4[2] = 8'h11;
    @(negedge clk);
    d4 = 32'h33221100;
    l4 = 4'b1111;
    v4 = 4'b1010;
    idx = 0;
    for (int i = 0; i < 30 && idx < 3; i++) begin
      @(negedge clk);
      if (grant4 != 4'b0000) begin
        chk("s6_grant4", 32'(grant4), 32'(exp_g4[idx]));
        chk("s6_data4",  32'(wr_data4), 32'(exp_d4[idx]));
        chk("s6_wr_en4", 32'(wr_en4), 32'h1);
        idx++;
      end
    end
    if (idx < 3) begin
      total++;
      bad++;
      $display("FAIL s6_timeout grants_seen=%0d expected=3", idx);
    end
    v4 = '0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
